// File: rtl/tsp16_arb_pkg.sv
// Shared constants and state type for the 8-way round-robin bus arbiter.
package tsp16_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;
endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Round-robin winner search: rotate req so ptr lands on bit 0, take the lowest
// set bit, then add ptr back to get the absolute requester index.
module rr_pick
  import tsp16_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;

  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[IDX_W'(i) + ptr];
    end
    // Descending scan so the lowest set bit is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    winner = off + ptr;
    any    = |req;
  end
endmodule

// File: rtl/bus_rr_arbiter.sv
// Two-state round-robin bus arbiter: the owner keeps the bus until it drops req,
// and every handover passes through one all-zero grant cycle.
// Define ARB_TIMEOUT_EN to revoke a grant after TIMEOUT cycles and pulse timeout.
module bus_rr_arbiter
  import tsp16_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout,
  output arb_state_t         state
);
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic             any;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must lie in 2..255");
  end

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
  logic       tmo_q;
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt       <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any) begin
            state     <= BUSY;
            gnt       <= NUM_REQ'(1) << winner;
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            ptr       <= winner + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        BUSY: begin
          // A release always wins over a revoke landing on the same edge.
          if (!req[gnt_idx]) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == TMO_LAST) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            tmo_q     <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
      endcase
    end
  end
endmodule
